// File: rtl/mpu_load_stream_if.sv
// mpu_load_stream_if: request/status, source beat stream and register-file write bundle (transpose_in under MPU_LOAD_TRANSPOSE_EN)
interface mpu_load_stream_if #(
  parameter int DATA_W     = 32,
  parameter int M_MAX      = 4,
  parameter int N_MAX      = 4,
  parameter int LANES      = 2,
  parameter int REG_ADDR_W = 2
);
  localparam int MB = $clog2(M_MAX + 1);
  localparam int NB = $clog2(N_MAX + 1);
  logic                    req_in;
  logic                    abort_in;
  logic [MB-1:0]           m_size_in;
  logic [NB-1:0]           n_size_in;
  logic [REG_ADDR_W-1:0]   addr_in;
`ifdef MPU_LOAD_TRANSPOSE_EN
  logic                    transpose_in;
`endif
  logic                    error_out;
  logic                    busy_out;
  logic                    done_out;
  logic                    src_valid_in;
  logic [LANES*DATA_W-1:0] src_data_in;
  logic                    src_ready_out;
  logic                    reg_ready_in;
  logic                    reg_en_out;
  logic [REG_ADDR_W-1:0]   reg_addr_out;
  logic [MB-1:0]           reg_i_out;
  logic [NB-1:0]           reg_j_out;
  logic [LANES-1:0]        reg_mask_out;
  logic [LANES*DATA_W-1:0] reg_data_out;
  logic [MB-1:0]           reg_m_out;
  logic [NB-1:0]           reg_n_out;
  modport slave (
`ifdef MPU_LOAD_TRANSPOSE_EN
    input transpose_in,
`endif
    input req_in, abort_in, m_size_in, n_size_in, addr_in, src_valid_in, src_data_in, reg_ready_in,
    output error_out, busy_out, done_out, src_ready_out, reg_en_out, reg_addr_out,
    output reg_i_out, reg_j_out, reg_mask_out, reg_data_out, reg_m_out, reg_n_out
  );
  modport master (
`ifdef MPU_LOAD_TRANSPOSE_EN
    output transpose_in,
`endif
    output req_in, abort_in, m_size_in, n_size_in, addr_in, src_valid_in, src_data_in, reg_ready_in,
    input error_out, busy_out, done_out, src_ready_out, reg_en_out, reg_addr_out,
    input reg_i_out, reg_j_out, reg_mask_out, reg_data_out, reg_m_out, reg_n_out
  );
endinterface

// File: rtl/mpu_load_stream.sv
// mpu_load_stream: multi-lane row-major matrix loader into the MPU register file; MPU_LOAD_TRANSPOSE_EN adds transposed writes
module mpu_load_stream #(
  parameter int DATA_W     = 32,
  parameter int M_MAX      = 4,
  parameter int N_MAX      = 4,
  parameter int LANES      = 2,
  parameter int REG_ADDR_W = 2
) (
  input logic clk,
  input logic rst,
  mpu_load_stream_if.slave bus
);
  localparam int MB = $clog2(M_MAX + 1);
  localparam int NB = $clog2(N_MAX + 1);
  localparam int CW = NB + $clog2(LANES + 1) + 1;
  typedef enum logic [1:0] {IDLE, REQUEST, LOAD} state_t;
  state_t state;
  logic [MB-1:0] m_r, row_ptr;
  logic [NB-1:0] n_r, col_ptr;
  logic [CW-1:0] col_sum;
  logic [LANES-1:0] mask;
  logic row_end, last, bad, tr, tr_in;
`ifdef MPU_LOAD_TRANSPOSE_EN
  assign tr_in = bus.transpose_in;
  always_ff @(posedge clk)
    if (rst) tr <= 1'b0;
    else if (state == IDLE && bus.req_in) tr <= tr_in;
`else
  assign tr_in = 1'b0;
  assign tr = 1'b0;
`endif
  always_comb begin
    col_sum = CW'(col_ptr) + CW'(LANES);
    row_end = col_sum >= CW'(n_r);
    last = row_end && (row_ptr == m_r - 1'b1);
    mask = '0;
    for (int k = 0; k < LANES; k++) mask[k] = (CW'(col_ptr) + CW'(k)) < CW'(n_r);
    bad = (bus.m_size_in == '0) || (bus.n_size_in == '0) ||
          (tr_in ? (32'(bus.n_size_in) > M_MAX || 32'(bus.m_size_in) > N_MAX)
                 : (32'(bus.m_size_in) > M_MAX || 32'(bus.n_size_in) > N_MAX));
  end
  // abort drops ready in the same cycle so no beat can slip in behind it
  assign bus.src_ready_out = (state == LOAD) && !bus.abort_in;
  assign bus.busy_out = state != IDLE;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      m_r <= '0;
      n_r <= '0;
      row_ptr <= '0;
      col_ptr <= '0;
      bus.error_out <= 1'b0;
      bus.done_out <= 1'b0;
      bus.reg_en_out <= 1'b0;
      bus.reg_addr_out <= '0;
      bus.reg_i_out <= '0;
      bus.reg_j_out <= '0;
      bus.reg_mask_out <= '0;
      bus.reg_data_out <= '0;
      bus.reg_m_out <= '0;
      bus.reg_n_out <= '0;
    end else begin
      bus.error_out <= 1'b0;
      bus.done_out <= 1'b0;
      bus.reg_en_out <= 1'b0;
      case (state)
        IDLE: if (bus.req_in) begin
          if (bad) bus.error_out <= 1'b1;
          else begin
            m_r <= bus.m_size_in;
            n_r <= bus.n_size_in;
            row_ptr <= '0;
            col_ptr <= '0;
            bus.reg_addr_out <= bus.addr_in;
            bus.reg_m_out <= tr_in ? MB'(bus.n_size_in) : bus.m_size_in;
            bus.reg_n_out <= tr_in ? NB'(bus.m_size_in) : bus.n_size_in;
            state <= REQUEST;
          end
        end
        REQUEST: state <= bus.abort_in ? IDLE : bus.reg_ready_in ? LOAD : REQUEST;
        LOAD: if (bus.abort_in) state <= IDLE;
        else if (bus.src_valid_in) begin
          bus.reg_en_out <= 1'b1;
          bus.reg_data_out <= bus.src_data_in;
          bus.reg_mask_out <= mask;
          bus.reg_i_out <= tr ? MB'(col_ptr) : row_ptr;
          bus.reg_j_out <= tr ? NB'(row_ptr) : col_ptr;
          col_ptr <= row_end ? '0 : col_sum[NB-1:0];
          row_ptr <= row_end ? row_ptr + 1'b1 : row_ptr;
          if (last) begin
            bus.done_out <= 1'b1;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mpu_load_stream.sv
// tb_mpu_load_stream: random-stimulus bench; expected writes come from a row-major matrix walk model
module tb_mpu_load_stream;
  localparam int DATA_W = 32, M_MAX = 4, N_MAX = 4, LANES = 2, REG_ADDR_W = 2;
  localparam int MB = $clog2(M_MAX + 1);
  localparam int NB = $clog2(N_MAX + 1);
  localparam int DW = LANES * DATA_W;
  logic clk = 1'b0, rst = 1'b1;
  int n_cmp = 0, n_err = 0;
  mpu_load_stream_if #(.DATA_W(DATA_W), .M_MAX(M_MAX), .N_MAX(N_MAX), .LANES(LANES), .REG_ADDR_W(REG_ADDR_W)) bus ();
  mpu_load_stream #(.DATA_W(DATA_W), .M_MAX(M_MAX), .N_MAX(N_MAX), .LANES(LANES), .REG_ADDR_W(REG_ADDR_W)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic set_tr(input bit t);
`ifdef MPU_LOAD_TRANSPOSE_EN
    bus.transpose_in = t;
`else
    if (t) $display("transpose requested without MPU_LOAD_TRANSPOSE_EN");
`endif
  endtask
  task automatic bad_req(input int m, input int n);
    bus.req_in = 1'b1;
    bus.m_size_in = MB'(m);
    bus.n_size_in = NB'(n);
    set_tr(1'b0);
    tick();
    bus.req_in = 1'b0;
    check("err_pulse", bus.error_out, 1);
    check("err_busy", bus.busy_out, 0);
    check("err_en", bus.reg_en_out, 0);
    tick();
    check("err_clear", bus.error_out, 0);
    check("err_busy2", bus.busy_out, 0);
  endtask
  // pv: percent chance of a valid beat per cycle, -1 alternates 1,0,1,0
  task automatic xfer(input int m, input int n, input bit tr, input int pv, input int gd,
                      input int abort_at, input bit ab_req);
    logic [DW-1:0] beats[$];
    int ei[$], ej[$];
    logic [LANES-1:0] em[$];
    logic [DW-1:0] d;
    logic [LANES-1:0] mk;
    logic [REG_ADDR_W-1:0] a;
    int total, sent, wr, cyc;
    bit pending, aborted;
    for (int r = 0; r < m; r++)
      for (int c = 0; c < n; c += LANES) begin
        for (int k = 0; k < LANES; k++) begin
          d[k*DATA_W +: DATA_W] = $urandom;
          mk[k] = (c + k) < n;
        end
        beats.push_back(d);
        em.push_back(mk);
        ei.push_back(tr ? c : r);
        ej.push_back(tr ? r : c);
      end
    total = beats.size();
    a = REG_ADDR_W'($urandom);
    bus.req_in = 1'b1;
    bus.abort_in = ab_req;
    bus.m_size_in = MB'(m);
    bus.n_size_in = NB'(n);
    bus.addr_in = a;
    set_tr(tr);
    tick();
    bus.req_in = 1'b0;
    bus.abort_in = 1'b0;
    bus.m_size_in = MB'($urandom);
    bus.n_size_in = NB'($urandom);
    bus.addr_in = REG_ADDR_W'($urandom);
    check("busy_req", bus.busy_out, 1);
    check("no_err", bus.error_out, 0);
    check("reg_m", bus.reg_m_out, tr ? n : m);
    check("reg_n", bus.reg_n_out, tr ? m : n);
    check("reg_addr", bus.reg_addr_out, a);
    repeat (gd) begin
      check("ready_wait", bus.src_ready_out, 0);
      tick();
    end
    bus.reg_ready_in = 1'b1;
    #1 check("ready_grant", bus.src_ready_out, 0);
    tick();
    sent = 0;
    wr = 0;
    cyc = 0;
    pending = 0;
    aborted = 0;
    forever begin
      if (pending) begin
        check("en", bus.reg_en_out, 1);
        check("i", bus.reg_i_out, ei[wr]);
        check("j", bus.reg_j_out, ej[wr]);
        check("mask", bus.reg_mask_out, em[wr]);
        check("data", bus.reg_data_out, beats[wr]);
        check("done", bus.done_out, wr == total - 1);
        wr++;
      end else begin
        check("idle_en", bus.reg_en_out, 0);
        check("idle_done", bus.done_out, 0);
      end
      if (wr == total || aborted) break;
      if (cyc > 1000) begin
        check("timeout", 1, 0);
        break;
      end
      bus.abort_in = (abort_at >= 0) && (sent == abort_at);
      bus.src_valid_in = sent < total && (pv < 0 ? (cyc % 2 == 0) : ($urandom_range(99) < pv));
      bus.src_data_in = sent < total ? beats[sent] : DW'($urandom);
      if (bus.abort_in) bus.src_valid_in = 1'b1;
      bus.req_in = ($urandom_range(3) == 0);
      #1 check("src_ready", bus.src_ready_out, !bus.abort_in);
      pending = bus.src_valid_in && !bus.abort_in;
      aborted = bus.abort_in;
      if (pending) sent++;
      tick();
      bus.abort_in = 1'b0;
      bus.src_valid_in = 1'b0;
      bus.req_in = 1'b0;
      cyc++;
    end
    check("busy_end", bus.busy_out, 0);
    check("ready_end", bus.src_ready_out, 0);
    bus.reg_ready_in = 1'b0;
    tick();
    check("post_done", bus.done_out, 0);
    check("post_en", bus.reg_en_out, 0);
    check("post_busy", bus.busy_out, 0);
  endtask
  initial begin
    bus.req_in = 0;
    bus.abort_in = 0;
    bus.m_size_in = '0;
    bus.n_size_in = '0;
    bus.addr_in = '0;
    bus.src_valid_in = 0;
    bus.src_data_in = '0;
    bus.reg_ready_in = 0;
    set_tr(1'b0);
    repeat (3) tick();
    check("rst_busy", bus.busy_out, 0);
    check("rst_err", bus.error_out, 0);
    check("rst_done", bus.done_out, 0);
    check("rst_en", bus.reg_en_out, 0);
    check("rst_ready", bus.src_ready_out, 0);
    check("rst_ij", {bus.reg_i_out, bus.reg_j_out, bus.reg_mask_out}, 0);
    check("rst_data", bus.reg_data_out, 0);
    check("rst_mn", {bus.reg_m_out, bus.reg_n_out, bus.reg_addr_out}, 0);
    rst = 1'b0;
    bus.abort_in = 1'b1;
    tick();
    bus.abort_in = 1'b0;
    check("abort_idle", bus.busy_out, 0);
    xfer(3, 3, 0, 100, 0, -1, 0);
    bad_req(0, 3);
    bad_req(3, N_MAX + 1);
    bad_req(M_MAX + 1, 2);
    bad_req(2, 0);
    xfer(2, 4, 0, -1, 0, -1, 0);
    xfer(2, 2, 0, 100, 5, -1, 0);
    xfer(4, 4, 0, 100, 0, 2, 0);
    xfer(1, 1, 0, 100, 0, -1, 1);
`ifdef MPU_LOAD_TRANSPOSE_EN
    xfer(2, 3, 1, 100, 0, -1, 0);
`endif
    repeat (15) begin
      bit t;
      t = 1'b0;
`ifdef MPU_LOAD_TRANSPOSE_EN
      t = 1'($urandom);
`endif
      xfer($urandom_range(M_MAX, 1), $urandom_range(N_MAX, 1), t, $urandom_range(100, 30),
           $urandom_range(3), ($urandom_range(3) == 0) ? $urandom_range(3) : -1, 1'($urandom));
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("final_busy", bus.busy_out, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
